// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the streaming perceptron: FSM states,
// accumulator sizing, saturation and BRAM word field layout.
package perceptron_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DRAIN  = 3'd2,
    SCALE  = 3'd3,
    WRITE  = 3'd4,
    RESULT = 3'd5
  } state_e;

  localparam int X_LSB = 0;
  // Wide enough to hold any scaled accumulator before saturation.
  localparam int SAT_W = 128;

  function automatic int w_lsb(input int w);
    return w;
  endfunction

  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n) + 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                        input int w);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    hi  = (one <<< (w - 1)) - one;
    lo  = -hi - one;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/perceptron_stream_engine_fixed_mac.sv
// Signed W x W multiply-accumulate with clear/enable, plus a combinational
// fixed-point rescale (arithmetic shift by FRAC) and saturation to W bits.
module fixed_mac
  import perceptron_pkg::*;
#(
  parameter int W     = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] w_i,
  output logic [W-1:0] y_o,
  output logic         pos_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [2*W-1:0]   prod_s;
  logic signed [ACC_W-1:0] shift_s;
  logic signed [SAT_W-1:0] wide_s;
  logic signed [SAT_W-1:0] sat_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= {ACC_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    prod_s = $signed(x_i) * $signed(w_i);
    acc_d  = acc_q;
    if (clr_i) begin
      acc_d = {ACC_W{1'b0}};
    end else if (en_i) begin
      acc_d = acc_q + {{(ACC_W-2*W){prod_s[2*W-1]}}, prod_s};
    end else begin
      acc_d = acc_q;
    end
    // Shift rounds toward -inf; saturation happens on the sign-extended result.
    shift_s = acc_q >>> FRAC;
    wide_s  = {{(SAT_W-ACC_W){shift_s[ACC_W-1]}}, shift_s};
    sat_s   = saturate(wide_s, W);
    y_o     = sat_s[W-1:0];
    pos_o   = !acc_q[ACC_W-1] && (acc_q != {ACC_W{1'b0}});
  end

endmodule

// File: rtl/perceptron_stream_engine.sv
// Perceptron engine: streams N (x, w) pairs out of BRAM through one MAC,
// then writes the scaled/saturated result back and offers it on valid/ready.
module perceptron_stream_engine
  import perceptron_pkg::*;
#(
  parameter int N        = 8,
  parameter int W        = 16,
  parameter int FRAC     = 8,
  parameter int AW       = 9,
  parameter int READ_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [AW-1:0]  base_addr_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           bram_en_o,
  output logic [AW-1:0]  bram_addr_o,
  input  logic [2*W-1:0] bram_rdata_i,
  output logic           bram_we_o,
  output logic [2*W-1:0] bram_wdata_o,
  output logic [W-1:0]   y_o,
  output logic           fire_o,
  output logic           y_valid_o,
  input  logic           y_ready_i
);

  localparam int ACC_W = acc_width(W, N);
  localparam int CNT_W = $clog2(N) + 1;
  localparam int W_LSB = w_lsb(W);

  state_e              state_q, state_d;
  logic [AW-1:0]       base_q, base_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [W-1:0]        y_q, y_d;
  logic                fire_q, fire_d;
  logic                y_valid_q, y_valid_d;
  logic                done_q, done_d;

  logic                issue_s;
  logic                mac_clr_s;
  logic                bram_en_s;
  logic                bram_we_s;
  logic [AW-1:0]       bram_addr_s;
  logic [W-1:0]        mac_y_s;
  logic                mac_pos_s;

  fixed_mac #(
    .W     (W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr_s),
    .en_i  (vld_q[READ_LAT-1]),
    .x_i   (bram_rdata_i[X_LSB +: W]),
    .w_i   (bram_rdata_i[W_LSB +: W]),
    .y_o   (mac_y_s),
    .pos_o (mac_pos_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= {AW{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      vld_q     <= {READ_LAT{1'b0}};
      y_q       <= {W{1'b0}};
      fire_q    <= 1'b0;
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
      y_q       <= y_d;
      fire_q    <= fire_d;
      y_valid_q <= y_valid_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    fire_d      = fire_q;
    y_valid_d   = y_valid_q;
    done_d      = 1'b0;
    issue_s     = 1'b0;
    mac_clr_s   = 1'b0;
    bram_en_s   = 1'b0;
    bram_we_s   = 1'b0;
    bram_addr_s = {AW{1'b0}};
    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d    = base_addr_i;
          cnt_d     = {CNT_W{1'b0}};
          mac_clr_s = 1'b1;
          state_d   = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        bram_en_s   = 1'b1;
        issue_s     = 1'b1;
        bram_addr_s = base_q + AW'(cnt_q);
        if (cnt_q == CNT_W'(N - 1)) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DRAIN: begin
        if (vld_q == {READ_LAT{1'b0}}) begin
          state_d = SCALE;
        end else begin
          state_d = DRAIN;
        end
      end
      SCALE: begin
        y_d     = mac_y_s;
        fire_d  = mac_pos_s;
        state_d = WRITE;
      end
      WRITE: begin
        bram_en_s   = 1'b1;
        bram_we_s   = 1'b1;
        bram_addr_s = base_q + AW'(N);
        y_valid_d   = 1'b1;
        state_d     = RESULT;
      end
      RESULT: begin
        if (y_ready_i) begin
          y_valid_d = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = RESULT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // One tag per issued read; the oldest tag lines up with returning data.
    vld_d = (vld_q << 1) | READ_LAT'(issue_s);
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign bram_en_o    = bram_en_s;
  assign bram_we_o    = bram_we_s;
  assign bram_addr_o  = bram_addr_s;
  assign bram_wdata_o = {{(W-1){1'b0}}, fire_q, y_q};
  assign y_o          = y_q;
  assign fire_o       = fire_q;
  assign y_valid_o    = y_valid_q;

endmodule

// File: tb/tb_perceptron_stream_engine.sv
// Directed bench: two engines (READ_LAT 1 and 3, N=4) against a simple BRAM
// model; expected results are hand-computed fixed-point values.
module tb_perceptron_stream_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start3;
  logic [8:0]  base_addr;
  logic        busy1, done1, en1, we1, fire1, yv1, ready1;
  logic [8:0]  addr1;
  logic [31:0] rdata1, wd1;
  logic [15:0] y1;
  logic        busy3, done3, en3, we3, fire3, yv3;
  logic        ready3 = 1'b1;
  logic [8:0]  addr3;
  logic [31:0] rdata3, wd3;
  logic [15:0] y3;

  logic [31:0] mem [0:511];
  logic [31:0] p0, p1, p2;
  int          wr_cnt1 = 0;
  logic [8:0]  wr_addr1 = 9'd0;
  logic [31:0] wr_data1 = 32'd0;
  int          rd_cnt = 0;
  logic [8:0]  rd_log [0:63];
  int          d3_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  perceptron_stream_engine #(.N(4), .W(16), .FRAC(8), .AW(9), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .base_addr_i(base_addr), .busy_o(busy1),
    .done_o(done1), .bram_en_o(en1), .bram_addr_o(addr1), .bram_rdata_i(rdata1),
    .bram_we_o(we1), .bram_wdata_o(wd1), .y_o(y1), .fire_o(fire1), .y_valid_o(yv1),
    .y_ready_i(ready1));

  perceptron_stream_engine #(.N(4), .W(16), .FRAC(8), .AW(9), .READ_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start_i(start3), .base_addr_i(base_addr), .busy_o(busy3),
    .done_o(done3), .bram_en_o(en3), .bram_addr_o(addr3), .bram_rdata_i(rdata3),
    .bram_we_o(we3), .bram_wdata_o(wd3), .y_o(y3), .fire_o(fire3), .y_valid_o(yv3),
    .y_ready_i(ready3));

  // BRAM model for dut1: one-cycle read latency, plus read/write logging.
  always @(posedge clk) begin
    if (en1 && !we1) begin
      rdata1 <= mem[addr1];
      rd_log[rd_cnt % 64] <= addr1;
      rd_cnt <= rd_cnt + 1;
    end
    if (we1) begin
      wr_cnt1  <= wr_cnt1 + 1;
      wr_addr1 <= addr1;
      wr_data1 <= wd1;
    end
  end

  // BRAM model for dut3: three-cycle read latency, done counter.
  always @(posedge clk) begin
    if (en3 && !we3) p0 <= mem[addr3];
    p1 <= p0;
    p2 <= p1;
    if (done3) d3_cnt <= d3_cnt + 1;
  end
  assign rdata3 = p2;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int base, input logic [15:0] x, input logic [15:0] w);
    for (int k = 0; k < 4; k++) mem[(base + k) % 512] = {w, x};
  endtask

  task automatic run_vec(input string tag, input int base, input logic [15:0] x,
                         input logic [15:0] w, input logic [15:0] ey, input logic ef);
    int wc0, rc0, d30, cyc;
    load(base, x, w);
    wc0 = wr_cnt1;
    rc0 = rd_cnt;
    d30 = d3_cnt;
    @(negedge clk);
    base_addr = base[8:0];
    start1 = 1'b1;
    start3 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
    cyc = 0;
    while (!yv1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_val({tag, "_latency"}, cyc, 8);
    check_val({tag, "_y"}, y1, ey);
    check_val({tag, "_fire"}, fire1, ef);
    @(negedge clk);
    check_val({tag, "_done"}, done1, 1'b1);
    check_val({tag, "_yv_drop"}, yv1, 1'b0);
    check_val({tag, "_wr_cnt"}, wr_cnt1 - wc0, 1);
    check_val({tag, "_wr_addr"}, wr_addr1, (base + 4) % 512);
    check_val({tag, "_wdata"}, wr_data1, {15'd0, ef, ey});
    check_val({tag, "_rd_cnt"}, rd_cnt - rc0, 4);
    for (int k = 0; k < 4; k++)
      check_val({tag, "_rd_addr"}, rd_log[(rc0 + k) % 64], (base + k) % 512);
    cyc = 0;
    while (d3_cnt == d30 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_val({tag, "_rl3_done"}, d3_cnt - d30, 1);
    check_val({tag, "_rl3_y"}, y3, ey);
    check_val({tag, "_rl3_fire"}, fire3, ef);
  endtask

  initial begin
    logic [15:0] yh;
    int          wc0, cyc;
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    rst = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    ready1 = 1'b1;
    base_addr = 9'd0;
    repeat (3) @(negedge clk);
    check_val("reset_outs", {busy1, done1, en1, we1, fire1, yv1, y1, addr1, wd1},
              64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_vec("pos_half", 100, 16'h0100, 16'h0080, 16'h0200, 1'b1);
    run_vec("neg_half", 108, 16'h0100, 16'hFF80, 16'hFE00, 1'b0);
    run_vec("sat_pos",  116, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    run_vec("sat_neg",  124, 16'h7FFF, 16'h8000, 16'h8000, 1'b0);
    run_vec("trunc",    132, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0);
    run_vec("zero",     140, 16'h0000, 16'h1234, 16'h0000, 1'b0);
    run_vec("wrap",     510, 16'h0100, 16'h0080, 16'h0200, 1'b1);

    // Back-pressure: result held, extra start ignored, single write and done.
    load(40, 16'h0100, 16'hFF80);
    wc0 = wr_cnt1;
    ready1 = 1'b0;
    @(negedge clk);
    base_addr = 9'd40;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    while (!yv1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_val("hold_valid", yv1, 1'b1);
    yh = y1;
    check_val("hold_y0", yh, 16'hFE00);
    for (int i = 0; i < 5; i++) begin
      start1 = (i == 2);
      @(negedge clk);
      check_val("hold_y", y1, yh);
      check_val("hold_fire", fire1, 1'b0);
      check_val("hold_yv", yv1, 1'b1);
      check_val("hold_nodone", done1, 1'b0);
    end
    start1 = 1'b0;
    check_val("hold_one_write", wr_cnt1 - wc0, 1);
    ready1 = 1'b1;
    @(negedge clk);
    check_val("hs_done", done1, 1'b1);
    check_val("hs_yv", yv1, 1'b0);
    @(negedge clk);
    check_val("hs_done_once", done1, 1'b0);
    check_val("hs_idle", busy1, 1'b0);
    repeat (3) @(negedge clk);
    check_val("start_ignored", busy1, 1'b0);
    check_val("y_kept", y1, 16'hFE00);
    check_val("hold_writes", wr_cnt1 - wc0, 1);

    // Abort during DRAIN.
    load(200, 16'h0100, 16'h0080);
    wc0 = wr_cnt1;
    @(negedge clk);
    base_addr = 9'd200;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    check_val("drain_state", {busy1, en1}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_outs", {busy1, done1, en1, we1, fire1, yv1, y1, addr1, wd1},
              64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_val("abort_no_write", wr_cnt1 - wc0, 0);
    check_val("abort_idle", busy1, 1'b0);
    run_vec("after_abort", 200, 16'h0100, 16'h0080, 16'h0200, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
